inst_wait_queue: RTL
====================

INST_WAIT_QUEUE -- requirements
Module: inst_wait_queue

Interface
REQ-001 Parameters SHALL be: DEPTH, default 4, queue entries (power of two, >= 2); DATA_W, default 32, instruction width; PC_W, default 32, PC width.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all flops rise-edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  IF offers an entry.
- in_ready  out  1  entry accepted when in_valid && in_ready.
- in_pc  in  PC_W  entry PC.
- in_has_exception  in  1  entry carries a fetch exception; no bus request was issued for it.
- in_ecode  in  6  exception code.
- in_esubcode  in  9  exception subcode.
- data_ok  in  1  in-order instruction response from the bus.
- rdata  in  DATA_W  response data.
- flush  in  1  exception/ertn flush.
- out_valid  out  1  head entry complete.
- out_ready  in  1  ID accepts head.
- out_pc  out  PC_W  head PC.
- out_inst  out  DATA_W  head instruction; 0 when head has an exception.
- out_has_exception  out  1  head exception flag.
- out_ecode  out  6  head ecode.
- out_esubcode  out  9  head esubcode.
- err_spurious  out  1  sticky: data_ok arrived with nothing to match.

Function
REQ-003 IF SHALL push a non-exception entry only in the cycle its bus request is accepted (addr_ok); responses SHALL be assumed to return in issue order.
REQ-004 Each entry SHALL hold pc, inst, exception fields, and a filled flag; exception entries SHALL be filled on push, with inst = 0.
REQ-005 in_ready SHALL be 1 iff count < DEPTH and (pending + discard_cnt) < DEPTH, where pending = number of stored unfilled entries; a pop in the same cycle SHALL NOT enable a push into a full queue.
REQ-006 A data_ok with discard_cnt > 0 SHALL be dropped and discard_cnt decremented by 1.
REQ-007 A data_ok with discard_cnt = 0 SHALL fill the oldest unfilled entry from head with rdata at the clock edge.
REQ-008 A data_ok with discard_cnt = 0 and pending = 0 SHALL be dropped and set err_spurious.
REQ-009 A push and a fill in the same cycle SHALL both take effect; a fill SHALL never target the entry being pushed that cycle.
REQ-010 out_valid SHALL be 1 iff count > 0, the head is filled, and flush = 0; out_* SHALL be driven from the head entry registers.
REQ-011 A pop occurs on out_valid && out_ready; pointers wrap modulo DEPTH.
REQ-012 Latency: an exception entry pushed at edge t SHALL be poppable in cycle t+1; a response filled at edge t SHALL be poppable in cycle t+1; data_ok-to-out_valid is 1 cycle with no combinational bypass.
REQ-013 On flush = 1, at the next edge all entries SHALL be invalidated, count and pointers SHALL go to 0, and discard_cnt SHALL become discard_cnt + pending + P - D, where P = 1 if a non-exception push handshake occurs this cycle (otherwise 0) and D = 1 if data_ok occurs this cycle (otherwise 0).
REQ-014 In a flush cycle, the push and the pop SHALL take no effect except for the P term in REQ-013; in_ready SHALL NOT depend on flush.
REQ-015 Pushes SHALL be accepted while discard_cnt > 0; new entries SHALL be filled only after discard_cnt reaches 0.
REQ-016 discard_cnt width SHALL be clog2(DEPTH)+1 and SHALL NOT exceed DEPTH (guaranteed by REQ-005).
REQ-017 err_spurious SHALL clear only on reset.

Reset
REQ-018 While rst = 0, the following SHALL be held at 0 asynchronously: count, pointers, discard_cnt, all filled flags, err_spurious, out_valid, and the stored entry fields.
REQ-019 in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-020 A reset in mid-operation SHALL discard all state with no residual discard count.

Verification
REQ-021 Push PCs 0x1C000000, 0x1C000004, 0x1C000008, 0x1C00000C (DEPTH=4) -> in_ready=0; data_ok with 0xAAAA0001 -> head out_inst=0xAAAA0001, out_valid next cycle; in-order pop.
REQ-022 Push exception entry (ecode=0x08, esubcode=0) behind two pending requests -> it pops only after both are filled and popped, with out_inst=0.
REQ-023 Three pending requests, flush coincident with one data_ok -> discard_cnt=2; the next two data_ok are dropped; the third fills a new entry pushed after the flush.
REQ-024 out_ready held 0 with full queue, data_ok on all four -> no loss; pops return 4 data words in order.
REQ-025 data_ok with empty queue and discard_cnt=0 -> err_spurious=1 until reset; queue state unchanged.
REQ-026 Assert rst mid-operation with discard_cnt=2 -> all outputs 0; after release, the first data_ok fills a new entry rather than being dropped.

Source files
------------

// File: rtl/inst_wait_queue.sv
// Instruction wait queue between IF and ID: holds issued fetches until their
// in-order bus responses arrive, and discards responses orphaned by a flush.
`timescale 1ns/1ps
module inst_wait_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_has_exception,
  input  logic [5:0]        in_ecode,
  input  logic [8:0]        in_esubcode,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] rdata,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_inst,
  output logic              out_has_exception,
  output logic [5:0]        out_ecode,
  output logic [8:0]        out_esubcode,
  output logic              err_spurious
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]   pc_q    [DEPTH];
  logic [DATA_W-1:0] inst_q  [DEPTH];
  logic [5:0]        ecode_q [DEPTH];
  logic [8:0]        esub_q  [DEPTH];
  logic [DEPTH-1:0]  exc_q;
  logic [DEPTH-1:0]  filled_q;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] pending;
  logic [CW-1:0] discard_cnt;
  logic          err_q;

  logic          push;
  logic          push_req;
  logic          pop;
  logic          resp_drop;
  logic          resp_fill;
  logic          resp_spur;
  logic          fill_hit;
  logic [AW-1:0] fill_idx;
  logic [CW:0]   outstanding;
  logic [CW:0]   flush_disc;

  // Bus requests still owed a response, whether kept or to be discarded.
  assign outstanding = {1'b0, pending} + {1'b0, discard_cnt};

  assign in_ready = rst && (count < CW'(DEPTH)) && (outstanding < (CW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign push_req = push && !in_has_exception;
  assign pop      = out_valid && out_ready;

  // Oldest unfilled stored entry, scanning forward from head.
  always_comb begin
    fill_hit = 1'b0;
    fill_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      if (!fill_hit && (CW'(i) < count) && !filled_q[head + AW'(i)]) begin
        fill_hit = 1'b1;
        fill_idx = head + AW'(i);
      end
    end
  end

  assign resp_drop = data_ok && (discard_cnt != '0);
  assign resp_fill = data_ok && (discard_cnt == '0) && fill_hit;
  assign resp_spur = data_ok && (discard_cnt == '0) && !fill_hit;

  // Responses still owed after a flush: kept-pending entries plus a request
  // issued this very cycle, less the response consumed this cycle.
  always_comb begin
    flush_disc = outstanding + (CW+1)'(push_req);
    if (data_ok && (flush_disc != '0)) flush_disc = flush_disc - (CW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      pending     <= '0;
      discard_cnt <= '0;
      filled_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (resp_spur) err_q <= 1'b1;
      if (flush) begin
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        pending     <= '0;
        filled_q    <= '0;
        discard_cnt <= CW'(flush_disc);
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        count       <= count + CW'(push) - CW'(pop);
        pending     <= pending + CW'(push_req) - CW'(resp_fill);
        discard_cnt <= discard_cnt - CW'(resp_drop);
        // pop, fill and push always address distinct slots
        if (pop)       filled_q[head]     <= 1'b0;
        if (resp_fill) filled_q[fill_idx] <= 1'b1;
        if (push)      filled_q[tail]     <= in_has_exception;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        inst_q[i]  <= '0;
        ecode_q[i] <= '0;
        esub_q[i]  <= '0;
      end
      exc_q <= '0;
    end else if (!flush) begin
      if (push) begin
        pc_q[tail]    <= in_pc;
        inst_q[tail]  <= '0;
        exc_q[tail]   <= in_has_exception;
        ecode_q[tail] <= in_ecode;
        esub_q[tail]  <= in_esubcode;
      end
      if (resp_fill) inst_q[fill_idx] <= rdata;
    end
  end

  assign out_valid         = (count != '0) && filled_q[head] && !flush;
  assign out_pc            = pc_q[head];
  assign out_inst          = exc_q[head] ? '0 : inst_q[head];
  assign out_has_exception = exc_q[head];
  assign out_ecode         = ecode_q[head];
  assign out_esubcode      = esub_q[head];
  assign err_spurious      = err_q;

endmodule
